// File: rtl/register_bank_demux_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | register_bank_demux_if : write/read bus of the 32x32 register bank       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface register_bank_demux_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  write;
  logic [ADDR_WIDTH-1:0] addr_w;
  logic [DATA_WIDTH-1:0] data_w;
  logic                  read;
  logic [ADDR_WIDTH-1:0] addr_r1;
  logic [ADDR_WIDTH-1:0] addr_r2;
  logic [DATA_WIDTH-1:0] data_r1;
  logic [DATA_WIDTH-1:0] data_r2;

  modport master (
    output write, addr_w, data_w, read, addr_r1, addr_r2,
    input  data_r1, data_r2
  );

  modport slave (
    input  write, addr_w, data_w, read, addr_r1, addr_r2,
    output data_r1, data_r2
  );
endinterface
`default_nettype wire

// File: rtl/register_bank_demux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | register_bank_demux : register file, one-hot write decode, r0 == 0,      |
// | two registered read ports with read-before-write ordering. Rev 1.0      |
// +--------------------------------------------------------------------------+
module register_bank_demux #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  register_bank_demux_if.slave   bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DEPTH-1:0]                 w_dec;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] w_word;
  logic [DATA_WIDTH-1:0]            r_data_r1;
  logic [DATA_WIDTH-1:0]            r_data_r2;

  for (genvar k = 0; k < DEPTH; k++) begin : g_word
    if (k == 0) begin : g_zero
      // Word 0 has no storage: its decoder line is masked and it reads as zero.
      assign w_dec[k]  = 1'b0;
      assign w_word[k] = '0;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] r_word;

      assign w_dec[k] = bus.write && (bus.addr_w == ADDR_WIDTH'(k));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_word <= '0;
        end else if (w_dec[k]) begin
          r_word <= bus.data_w;
        end
      end

      assign w_word[k] = r_word;
    end
  end

  // Reads sample the pre-edge storage, so a same-cycle write is seen next READ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_r1 <= '0;
      r_data_r2 <= '0;
    end else if (bus.read) begin
      r_data_r1 <= w_word[bus.addr_r1];
      r_data_r2 <= w_word[bus.addr_r2];
    end
  end

  assign bus.data_r1 = r_data_r1;
  assign bus.data_r2 = r_data_r2;
endmodule
`default_nettype wire

// File: tb/tb_register_bank_demux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_register_bank_demux : directed + random checks of register_bank_demux |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_register_bank_demux;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  logic [DW-1:0] model [32];
  logic [DW-1:0] exp1;
  logic [DW-1:0] exp2;

  register_bank_demux_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  register_bank_demux #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = '0;
    exp1 = '0;
    exp2 = '0;
  endtask

  // Drive one cycle from a negedge, update the reference at posedge, return at next negedge.
  task automatic step(input logic w, input logic [AW-1:0] aw, input logic [DW-1:0] dw,
                      input logic r, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    bus.write   = w;
    bus.addr_w  = aw;
    bus.data_w  = dw;
    bus.read    = r;
    bus.addr_r1 = a1;
    bus.addr_r2 = a2;
    @(posedge clk);
    if (r) begin
      exp1 = model[a1];
      exp2 = model[a2];
    end
    if (w && aw != 0) model[aw] = dw;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    model_clear();
    rst_n = 1'b0;
    bus.write = 1'b0; bus.addr_w = '0; bus.data_w = '0;
    bus.read  = 1'b0; bus.addr_r1 = '0; bus.addr_r2 = '0;
    repeat (2) @(negedge clk);
    check("reset_r1", bus.data_r1, 32'h0);
    check("reset_r2", bus.data_r2, 32'h0);
    rst_n = 1'b1;

    // Asynchronous reset clears storage and outputs immediately.
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
    step(1'b0, '0, '0, 1'b1, 5'd5, 5'd5);
    check("pre_rst_r1", bus.data_r1, 32'hDEADBEEF);
    bus.write = 1'b1; bus.addr_w = 5'd9; bus.data_w = 32'h99999999;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_r1", bus.data_r1, 32'h0);
    check("async_rst_r2", bus.data_r2, 32'h0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, '0, '0, 1'b1, 5'd5, 5'd9);
    check("post_rst_r5", bus.data_r1, 32'h0);
    check("aborted_wr_r9", bus.data_r2, 32'h0);

    // Write every address, read back in pairs (k, 31-k).
    for (int k = 1; k < 32; k++) step(1'b1, AW'(k), 32'hA5000000 + DW'(k), 1'b0, '0, '0);
    for (int k = 0; k < 32; k++) begin
      step(1'b0, '0, '0, 1'b1, AW'(k), AW'(31 - k));
      check("pair_r1", bus.data_r1, (k == 0) ? 32'h0 : 32'hA5000000 + DW'(k));
      check("pair_r2", bus.data_r2, (k == 31) ? 32'h0 : 32'hA5000000 + DW'(31 - k));
    end
    step(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, '0, '0);
    step(1'b0, '0, '0, 1'b1, 5'd0, 5'd0);
    check("r0_zero", bus.data_r1, 32'h0);

    // Same-cycle write/read of r7 returns the old value.
    step(1'b1, 5'd7, 32'h11111111, 1'b0, '0, '0);
    step(1'b1, 5'd7, 32'h22222222, 1'b1, 5'd7, 5'd7);
    check("collide_r1_old", bus.data_r1, 32'h11111111);
    check("collide_r2_old", bus.data_r2, 32'h11111111);
    step(1'b0, '0, '0, 1'b1, 5'd7, 5'd7);
    check("collide_r1_new", bus.data_r1, 32'h22222222);
    check("collide_r2_new", bus.data_r2, 32'h22222222);

    // Outputs hold while READ is low.
    step(1'b1, 5'd3, 32'h0000CAFE, 1'b0, '0, '0);
    step(1'b0, '0, '0, 1'b1, 5'd3, 5'd3);
    check("hold_setup", bus.data_r1, 32'h0000CAFE);
    for (int i = 0; i < 10; i++) begin
      step(i == 0, 5'd3, 32'h0, 1'b0, AW'(i + 10), AW'(i));
      check("hold_r1", bus.data_r1, 32'h0000CAFE);
    end
    step(1'b0, '0, '0, 1'b1, 5'd3, 5'd3);
    check("hold_release", bus.data_r1, 32'h0);

    // Decoder isolation after a fresh reset.
    @(negedge clk); rst_n = 1'b0; model_clear();
    @(negedge clk); rst_n = 1'b1;
    step(1'b1, 5'd16, 32'h12345678, 1'b0, '0, '0);
    for (int k = 0; k < 32; k++) begin
      step(1'b0, '0, '0, 1'b1, AW'(k), AW'(k));
      check("iso_r1", bus.data_r1, (k == 16) ? 32'h12345678 : 32'h0);
      check("iso_r2", bus.data_r2, (k == 16) ? 32'h12345678 : 32'h0);
    end

    // Random traffic against the read-before-write model.
    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom),
           1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)));
      check("rand_r1", bus.data_r1, exp1);
      check("rand_r2", bus.data_r2, exp2);
    end

    idle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
